// File: rtl/and2_scoreboard_if.sv
// rtl/and2_scoreboard_if.sv - stimulus/response and status bundle for the and2 response checker
interface and2_scoreboard_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [WIDTH-1:0] first_fail_a;
    logic [WIDTH-1:0] first_fail_b;
    logic [WIDTH-1:0] first_fail_y;

    modport master (
        output start, num_vectors, in_valid, a, b, y,
        input  busy, done, pass, pass_cnt, fail_cnt,
        input  first_fail_a, first_fail_b, first_fail_y
    );

    modport slave (
        input  start, num_vectors, in_valid, a, b, y,
        output busy, done, pass, pass_cnt, fail_cnt,
        output first_fail_a, first_fail_b, first_fail_y
    );
endinterface

// File: rtl/and2_scoreboard.sv
// rtl/and2_scoreboard.sv - checks returned y against a & b, counts pass/fail, captures first mismatch
module and2_scoreboard #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    and2_scoreboard_if.slave   s_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_cmp_valid;
    logic [WIDTH-1:0] r_cmp_a;
    logic [WIDTH-1:0] r_cmp_b;
    logic [WIDTH-1:0] r_cmp_y;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic [WIDTH-1:0] r_ff_y;

    logic             w_launch;
    logic             w_accept;
    logic             w_match;
    logic             w_all_compared;

    // start is only honoured outside RUN; samples are only taken inside RUN
    assign w_launch       = (r_state != S_RUN) && s_if.start;
    assign w_accept       = (r_state == S_RUN) && s_if.in_valid && (r_vec_cnt != r_num);
    assign w_match        = (r_cmp_y == (r_cmp_a & r_cmp_b));
    assign w_all_compared = (r_vec_cnt == r_num) && !r_cmp_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (s_if.start) w_next_state = S_RUN;
            S_RUN:   if (w_all_compared) w_next_state = S_DONE;
            S_DONE:  if (s_if.start) w_next_state = S_RUN;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        s_if.busy = 1'b0;
        s_if.done = 1'b0;
        case (r_state)
            S_RUN:   s_if.busy = 1'b1;
            S_DONE:  s_if.done = 1'b1;
            default: ;
        endcase
        s_if.pass = (r_state == S_DONE) && (r_fail_cnt == '0);
    end

    // Compare stage sits one edge behind acceptance; the FSM waits for it to drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_num       <= '0;
            r_vec_cnt   <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_cmp_y     <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_y      <= '0;
        end else begin
            r_cmp_valid <= w_accept;
            if (w_accept) begin
                r_cmp_a   <= s_if.a;
                r_cmp_b   <= s_if.b;
                r_cmp_y   <= s_if.y;
                r_vec_cnt <= r_vec_cnt + 1'b1;
            end
            if (w_launch) begin
                r_num      <= s_if.num_vectors;
                r_vec_cnt  <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_ff_a     <= '0;
                r_ff_b     <= '0;
                r_ff_y     <= '0;
            end else if (r_cmp_valid) begin
                if (w_match) begin
                    if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
                end else begin
                    if (r_fail_cnt == '0) begin
                        r_ff_a <= r_cmp_a;
                        r_ff_b <= r_cmp_b;
                        r_ff_y <= r_cmp_y;
                    end
                    if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
                end
            end
        end
    end

    assign s_if.pass_cnt     = r_pass_cnt;
    assign s_if.fail_cnt     = r_fail_cnt;
    assign s_if.first_fail_a = r_ff_a;
    assign s_if.first_fail_b = r_ff_b;
    assign s_if.first_fail_y = r_ff_y;
endmodule

// File: tb/tb_and2_scoreboard.sv
// tb/tb_and2_scoreboard.sv - table-driven and randomized self-checking bench for and2_scoreboard
module tb_and2_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    and2_scoreboard_if #(.WIDTH(2), .CNT_W(8)) sb_if ();

    and2_scoreboard #(.WIDTH(2), .CNT_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_if  (sb_if.slave)
    );

    typedef struct {
        logic [7:0]      num;
        int              n;
        logic [7:0]      v;
        logic [7:0][1:0] a;
        logic [7:0][1:0] b;
        logic [7:0][1:0] y;
        logic            sv;
        logic            ms;
        int              e_pass;
        int              e_fail;
        logic            e_ok;
        logic [1:0]      e_ffa;
        logic [1:0]      e_ffb;
        logic [1:0]      e_ffy;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t blank(input logic [7:0] num);
        vec_t t;
        t = '{default: '0};
        t.num = num;
        return t;
    endfunction

    function automatic vec_t put(input vec_t t, input logic vld,
                                 input logic [1:0] a, input logic [1:0] b, input logic [1:0] y);
        vec_t r;
        r = t;
        r.v[r.n] = vld;
        r.a[r.n] = a;
        r.b[r.n] = b;
        r.y[r.n] = y;
        r.n      = r.n + 1;
        return r;
    endfunction

    function automatic vec_t expect_res(input vec_t t, input int p, input int f, input logic ok,
                                        input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fy);
        vec_t r;
        r = t;
        r.e_pass = p; r.e_fail = f; r.e_ok = ok;
        r.e_ffa = fa; r.e_ffb = fb; r.e_ffy = fy;
        return r;
    endfunction

    // Reference: walk the valid samples, keep the first num of them, grade each one
    function automatic vec_t model(input vec_t t);
        vec_t r;
        int   taken;
        r = t;
        taken = 0;
        r.e_pass = 0; r.e_fail = 0;
        r.e_ffa = 2'd0; r.e_ffb = 2'd0; r.e_ffy = 2'd0;
        for (int i = 0; i < t.n; i++) begin
            if (t.v[i] && taken < int'(t.num)) begin
                taken++;
                if (t.y[i] == (t.a[i] & t.b[i])) begin
                    r.e_pass++;
                end else begin
                    if (r.e_fail == 0) begin
                        r.e_ffa = t.a[i]; r.e_ffb = t.b[i]; r.e_ffy = t.y[i];
                    end
                    r.e_fail++;
                end
            end
        end
        r.e_ok = (r.e_fail == 0);
        return r;
    endfunction

    task automatic drive_idle();
        sb_if.start = 1'b0; sb_if.in_valid = 1'b0;
        sb_if.a = 2'd0; sb_if.b = 2'd0; sb_if.y = 2'd0;
    endtask

    task automatic apply(input vec_t t, input string nm);
        int k;
        @(negedge clk);
        sb_if.start       = 1'b1;
        sb_if.num_vectors = t.num;
        sb_if.in_valid    = t.sv;
        sb_if.a = 2'd3; sb_if.b = 2'd3; sb_if.y = 2'd0;
        @(negedge clk);
        chk({nm, ".busy_after_start"}, int'(sb_if.busy), 1);
        chk({nm, ".done_after_start"}, int'(sb_if.done), 0);
        for (int i = 0; i < t.n; i++) begin
            sb_if.start       = (t.ms && i == 1);
            sb_if.num_vectors = (t.ms && i == 1) ? 8'hFF : t.num;
            sb_if.in_valid    = t.v[i];
            sb_if.a = t.a[i]; sb_if.b = t.b[i]; sb_if.y = t.y[i];
            @(negedge clk);
        end
        drive_idle();
        k = 0;
        while (!sb_if.done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({nm, ".done"}, int'(sb_if.done), 1);
        chk({nm, ".pass_cnt"}, int'(sb_if.pass_cnt), t.e_pass);
        chk({nm, ".fail_cnt"}, int'(sb_if.fail_cnt), t.e_fail);
        chk({nm, ".pass"}, int'(sb_if.pass), int'(t.e_ok));
        chk({nm, ".ff_a"}, int'(sb_if.first_fail_a), int'(t.e_ffa));
        chk({nm, ".ff_b"}, int'(sb_if.first_fail_b), int'(t.e_ffb));
        chk({nm, ".ff_y"}, int'(sb_if.first_fail_y), int'(t.e_ffy));
        chk({nm, ".busy_end"}, int'(sb_if.busy), 0);
        repeat (2) @(negedge clk);
        chk({nm, ".done_hold"}, int'(sb_if.done), 1);
        chk({nm, ".pass_cnt_hold"}, int'(sb_if.pass_cnt), t.e_pass);
    endtask

    initial begin
        vec_t t;
        int   c;
        sb_if.num_vectors = 8'd0;
        drive_idle();

        tbl[0] = blank(8'd4);
        tbl[0] = put(tbl[0], 1, 1, 1, 1);
        tbl[0] = put(tbl[0], 1, 3, 2, 2);
        tbl[0] = put(tbl[0], 1, 2, 1, 0);
        tbl[0] = put(tbl[0], 1, 3, 3, 3);
        tbl[0] = expect_res(tbl[0], 4, 0, 1, 0, 0, 0);
        tbl[1] = blank(8'd3);
        tbl[1] = put(tbl[1], 1, 1, 1, 1);
        tbl[1] = put(tbl[1], 1, 3, 3, 1);
        tbl[1] = put(tbl[1], 1, 2, 3, 0);
        tbl[1] = expect_res(tbl[1], 1, 2, 0, 3, 3, 1);
        tbl[2] = blank(8'd2);
        tbl[2] = put(tbl[2], 1, 1, 3, 1);
        tbl[2] = put(tbl[2], 0, 3, 3, 0);
        tbl[2] = put(tbl[2], 0, 3, 3, 0);
        tbl[2] = put(tbl[2], 1, 2, 2, 2);
        tbl[2] = put(tbl[2], 1, 3, 1, 1);
        tbl[2] = expect_res(tbl[2], 2, 0, 1, 0, 0, 0);
        tbl[3] = blank(8'd0);
        tbl[3] = expect_res(tbl[3], 0, 0, 1, 0, 0, 0);
        tbl[4] = blank(8'd1);
        tbl[4] = put(tbl[4], 1, 2, 2, 0);
        tbl[4] = expect_res(tbl[4], 0, 1, 0, 2, 2, 0);
        tbl[5] = blank(8'd1);
        tbl[5].sv = 1'b1;
        tbl[5] = put(tbl[5], 1, 1, 1, 1);
        tbl[5] = expect_res(tbl[5], 1, 0, 1, 0, 0, 0);
        tbl[6] = blank(8'd2);
        tbl[6].ms = 1'b1;
        tbl[6] = put(tbl[6], 1, 2, 3, 2);
        tbl[6] = put(tbl[6], 1, 1, 2, 0);
        tbl[6] = expect_res(tbl[6], 2, 0, 1, 0, 0, 0);

        // Reset with in_valid toggling, then idle samples must be ignored
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sb_if.in_valid = ~sb_if.in_valid;
            sb_if.a = 2'd3; sb_if.b = 2'd3; sb_if.y = 2'd0;
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        chk("reset.busy", int'(sb_if.busy), 0);
        chk("reset.done", int'(sb_if.done), 0);
        chk("reset.pass", int'(sb_if.pass), 0);
        chk("reset.pass_cnt", int'(sb_if.pass_cnt), 0);
        chk("reset.fail_cnt", int'(sb_if.fail_cnt), 0);
        chk("reset.ff", int'({sb_if.first_fail_a, sb_if.first_fail_b, sb_if.first_fail_y}), 0);
        sb_if.in_valid = 1'b1; sb_if.a = 2'd1; sb_if.b = 2'd2; sb_if.y = 2'd3;
        repeat (3) @(negedge clk);
        drive_idle();
        @(negedge clk);
        chk("idle_ignore.fail_cnt", int'(sb_if.fail_cnt), 0);
        chk("idle_ignore.busy", int'(sb_if.busy), 0);

        for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Mid-run reset aborts and discards the pending compare
        @(negedge clk);
        sb_if.start = 1'b1; sb_if.num_vectors = 8'd5;
        @(negedge clk);
        sb_if.start = 1'b0;
        sb_if.in_valid = 1'b1; sb_if.a = 2'd1; sb_if.b = 2'd1; sb_if.y = 2'd1;
        @(negedge clk);
        sb_if.a = 2'd2; sb_if.b = 2'd2; sb_if.y = 2'd1;
        @(negedge clk);
        rst = 1'b1;
        sb_if.a = 2'd3; sb_if.b = 2'd3; sb_if.y = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("midrst.busy", int'(sb_if.busy), 0);
        chk("midrst.done", int'(sb_if.done), 0);
        chk("midrst.pass_cnt", int'(sb_if.pass_cnt), 0);
        chk("midrst.fail_cnt", int'(sb_if.fail_cnt), 0);
        t = blank(8'd1);
        t = put(t, 1, 1, 1, 1);
        t = expect_res(t, 1, 0, 1, 0, 0, 0);
        apply(t, "midrst_fresh");

        for (int r = 0; r < 40; r++) begin
            t = blank(8'd0);
            c = 0;
            for (int i = 0; i < 8; i++) begin
                logic       vld;
                logic [1:0] ra, rb, ry;
                vld = ($urandom_range(0, 3) != 0);
                ra  = 2'($urandom);
                rb  = 2'($urandom);
                ry  = ($urandom_range(0, 1) == 1) ? (ra & rb) : 2'($urandom);
                t   = put(t, vld, ra, rb, ry);
                if (vld) c++;
            end
            t.num = 8'($urandom_range(0, c));
            t.sv  = 1'($urandom);
            t.ms  = (t.num != 8'd0) && ($urandom_range(0, 1) == 1);
            t = model(t);
            apply(t, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/and2_scoreboard.md
Name: and2_scoreboard

Overview:
- Sequential response checker for the 2-bit AND datapath.
- Samples each applied operand pair (a, b) and the returned result y under a valid strobe, and computes the expected a & b internally.
- Counts passing and failing vectors, captures the first mismatch, and reports done/pass once a programmed number of vectors has been checked.
- Sits beside the and2 datapath as the checking end of the stimulus/response interface, so benches self-check instead of relying on printed values.

Parameters:
- WIDTH, 2, operand and result width in bits.
- CNT_W, 8, width of the vector, pass and fail counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; arms a check run.
- num_vectors  input  CNT_W  vectors to check per run; latched on start.
- in_valid  input  1  a, b, y valid this cycle.
- a  input  WIDTH  operand A as applied to the datapath.
- b  input  WIDTH  operand B as applied to the datapath.
- y  input  WIDTH  result returned by the datapath.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when fail_cnt == 0.
- pass_cnt  output  CNT_W  matching vectors this run.
- fail_cnt  output  CNT_W  mismatching vectors this run.
- first_fail_a  output  WIDTH  a of first mismatch.
- first_fail_b  output  WIDTH  b of first mismatch.
- first_fail_y  output  WIDTH  y of first mismatch.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state IDLE;
  - busy=0, done=0, pass=0;
  - pass_cnt, fail_cnt, vec_cnt all 0;
  - first_fail_a/b/y = 0;
  - the compare stage invalid.
- Reset asserted mid-run aborts the run. The compare-stage sample is discarded and not counted.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 -> RUN. On entry, latch num_vectors, clear all counters and first_fail_*. in_valid is ignored in IDLE.
  - RUN: each cycle with in_valid=1 registers {a, b, y} into the compare stage and increments vec_cnt.
    - Once vec_cnt reaches the latched count, further in_valid is ignored.
    - Transition to DONE on the cycle after the last accepted vector has been compared, so its result is counted.
  - RUN with latched num_vectors = 0: go directly to DONE next cycle with pass=1 and both counters 0.
  - DONE: outputs hold. start=1 -> RUN with the same clear/latch as from IDLE.
  - start while in RUN is ignored.
- Compare stage timing:
  - A vector accepted at edge N is compared at edge N+1.
  - pass_cnt or fail_cnt updates at edge N+1 (one-cycle latency).
  - Back-to-back in_valid every cycle is supported at full throughput.
- Match rule: y == (a & b) over all WIDTH bits, bitwise and unsigned. There are no X-handling requirements.
- First mismatch capture:
  - first_fail_* load only on the first mismatch of a run (fail_cnt transitioning 0 -> 1).
  - Later mismatches leave them unchanged.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- pass = done && (fail_cnt == 0). pass is combinationally derived from registered state and is glitch-free at the clock edge.
- If start and in_valid are both high in IDLE or DONE, the in_valid sample is not counted.

Test Plan:
- Reset check: rst=1 for 2 cycles with in_valid toggling -> busy=0, done=0, pass=0, all counters 0, first_fail_*=0.
- Clean run: start with num_vectors=4, then apply (a,b,y) = (1,1,1), (3,2,2), (2,1,0), (3,3,3) on consecutive cycles -> pass_cnt=4, fail_cnt=0, done=1 one cycle after the last compare, pass=1.
- Fault capture: num_vectors=3, apply (1,1,1), (3,3,1), (2,3,0) -> fail_cnt=2, pass_cnt=1, first_fail = a=3, b=3, y=1, pass=0.
- Gapped and excess valids: num_vectors=2, in_valid pattern 1,0,0,1,1 with correct results -> pass_cnt=2, the fifth sample is ignored, done=1.
- Mid-run reset: num_vectors=5, rst=1 after 2 vectors -> state IDLE, all counters 0, done=0. A fresh start with num_vectors=1 and (1,1,1) -> pass_cnt=1, pass=1.
- Zero and restart: start with num_vectors=0 -> done=1, pass=1 within 2 cycles. Then start again with num_vectors=1 and (2,2,0) -> fail_cnt=1, first_fail_y=0.
